fruit_slot_scheduler: RTL and testbench
=======================================

Name: fruit_slot_scheduler

Overview:
- Owns N_SLOTS fruit objects: spawns, advances them once per video frame with gravity, retires them when they fall off-screen.
- Each pixel, arbitrates which active fruit owns (DrawX, DrawY) and presents that fruit's position, size and ID to the color mapper.
- Sits between the game-logic spawner and color_mapper. Replaces the single hard-wired FruitX/FruitY source.

Parameters:
- N_SLOTS, 4, number of fruit slots (1..8); slot index width is clog2(N_SLOTS), minimum 1.
- FRUIT_SIZE, 10'd32, square sprite edge in pixels, applied to every slot.
- GRAVITY, 8'sd1, signed increment added to vy every frame.
- Y_SPAWN, 11'sd479, initial Y of every spawned fruit.
- Y_MAX, 11'sd480, a falling fruit with y > Y_MAX is retired.
- X_MAX, 10'd607, largest legal X (640 - FRUIT_SIZE - 1).

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, synchronous active-high reset.
- frame_clk, in, 1, vsync level from the VGA controller, synchronous to Clk; a rising edge marks a frame tick.
- DrawX, in, 10, current pixel X.
- DrawY, in, 10, current pixel Y.
- spawn_req, in, 1, spawn request; held high until spawn_ack.
- spawn_x, in, 10, initial X; values > X_MAX are clamped to X_MAX.
- spawn_vx, in, 8, initial signed X velocity.
- spawn_vy, in, 8, initial signed Y velocity; negative means upward.
- spawn_ack, out, 1, one-cycle pulse when the spawn is accepted.
- FruitX, out, 10, X of the winning fruit, registered.
- FruitY, out, 10, Y[9:0] of the winning fruit, registered.
- Fruit_size, out, 10, FRUIT_SIZE when fruit_on, else 0, registered.
- fruit_on, out, 1, some active fruit covers the pixel, registered.
- fruit_id, out, clog2(N_SLOTS), index of the winning slot, registered.
- active_mask, out, N_SLOTS, per-slot active flags.
- missed, out, 1, one-cycle pulse per slot retired.

Behaviour:
- Reset:
  - All slots inactive; x, y, vx, vy cleared.
  - FSM goes to IDLE.
  - All outputs 0.
  - The frame_clk edge-detect register is loaded with the current frame_clk, so a high level during reset produces no tick.
- A Reset asserted mid-UPDATE aborts the sweep. No missed pulse is emitted for the aborted frame.
- Frame tick: frame_clk is 1 this cycle and was 0 the previous cycle.
- FSM IDLE:
  - On a tick, go to UPDATE with idx = 0. The tick has priority over a same-cycle spawn; the spawn stays pending.
  - Otherwise, if spawn_req is high and a free slot exists, go to SPAWN.
  - If spawn_req is high and no slot is free, stay in IDLE and give no ack; the request waits.
- FSM SPAWN, one cycle:
  - Load the lowest-index free slot: x = clamped spawn_x, y = Y_SPAWN, vx, vy from the inputs, active = 1.
  - Pulse spawn_ack in this cycle, then return to IDLE.
- FSM UPDATE, one slot per cycle, N_SLOTS cycles. For each active slot idx:
  - vy' = vy + GRAVITY, saturating to [-128, 127].
  - y' = y + vy' as 11-bit signed; vy' is sign-extended.
  - x' = x + vx.
    - If x' < 0, then x' = 0 and vx = -vx.
    - If x' > X_MAX, then x' = X_MAX and vx = -vx.
    - vx = -128 negates to 127.
  - If vy' > 0 and y' > Y_MAX, clear active and pulse missed in that cycle.
  - Inactive slots are skipped but still consume their cycle.
  - After idx = N_SLOTS-1, return to IDLE.
- A tick that arrives during UPDATE is dropped.
- Pixel arbitration, one-cycle latency:
  - Slot i hits when it is active, y >= 0, (DrawX - x) mod 1024 < FRUIT_SIZE and (DrawY - y[9:0]) mod 1024 < FRUIT_SIZE.
  - The lowest-index hit wins and is registered into FruitX, FruitY, fruit_id and fruit_on.
  - With no hit, fruit_on = 0 and FruitX, FruitY, fruit_id = 0.
- Arbitration reads the live slot registers, so the pixel path sees updated values during UPDATE. Updates happen at vsync, so no visible tear.
- active_mask reflects slot flags directly, with no extra latency.

Test Plan:
- Reset with frame_clk held high, then release -> no UPDATE entry; active_mask = 0; all outputs 0.
- spawn_req with spawn_x = 100, vx = 2, vy = -10 -> spawn_ack one cycle later; slot 0 active; x = 100, y = 479. After one tick: vy = -9, y = 470, x = 102.
- Fill all 4 slots, then assert a 5th spawn_req -> no ack while full. Retire slot 2 via fall-off -> missed pulse; next ack loads slot 2.
- Slot 0 at x = 606, vx = 5, one tick -> x = 607 and vx = -5. Slot at x = 1, vx = -3 -> x = 0 and vx = 3.
- Slots 1 and 3 overlapping at (200, 200); drive DrawX/DrawY = (210, 210) -> next cycle fruit_on = 1, fruit_id = 1, FruitX = 200, Fruit_size = 32. Drive (250, 250) -> fruit_on = 0.
- Tick and spawn_req in the same cycle -> N_SLOTS UPDATE cycles first; spawn_ack asserted in cycle N_SLOTS+2 after the tick.

Source files
------------

// File: rtl/fruit_slot_scheduler_if.sv
// Spawner / pixel-pipe bundle for fruit_slot_scheduler.
// master = game logic and VGA side, slave = scheduler.
interface fruit_slot_scheduler_if #(
  parameter int N_SLOTS = 4
);
  localparam int IDW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  logic               frame_clk;
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               spawn_req;
  logic [9:0]         spawn_x;
  logic [7:0]         spawn_vx;
  logic [7:0]         spawn_vy;
  logic               spawn_ack;
  logic [9:0]         FruitX;
  logic [9:0]         FruitY;
  logic [9:0]         Fruit_size;
  logic               fruit_on;
  logic [IDW-1:0]     fruit_id;
  logic [N_SLOTS-1:0] active_mask;
  logic               missed;

  modport master (
    output frame_clk, DrawX, DrawY,
    output spawn_req, spawn_x, spawn_vx, spawn_vy,
    input  spawn_ack, FruitX, FruitY, Fruit_size,
    input  fruit_on, fruit_id, active_mask, missed
  );

  modport slave (
    input  frame_clk, DrawX, DrawY,
    input  spawn_req, spawn_x, spawn_vx, spawn_vy,
    output spawn_ack, FruitX, FruitY, Fruit_size,
    output fruit_on, fruit_id, active_mask, missed
  );
endinterface

// File: rtl/fruit_slot_scheduler.sv
// Fruit slot pool: spawn, per-frame gravity update, retire,
// and per-pixel lowest-index arbitration for the color mapper.
module fruit_slot_scheduler #(
  parameter int                 N_SLOTS    = 4,
  parameter logic [9:0]         FRUIT_SIZE = 10'd32,
  parameter logic signed [7:0]  GRAVITY    = 8'sd1,
  parameter logic signed [10:0] Y_SPAWN    = 11'sd479,
  parameter logic signed [10:0] Y_MAX      = 11'sd480,
  parameter logic [9:0]         X_MAX      = 10'd607
) (
  input logic                   Clk,
  input logic                   Reset,
  fruit_slot_scheduler_if.slave bus
);
  localparam int IDW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [IDW-1:0] LAST = IDW'(N_SLOTS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPAWN,
    S_UPDATE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic [IDW-1:0] r_idx;
  logic [IDW-1:0] w_idx_nxt;
  logic r_frame_q;

  logic [9:0]         r_x  [N_SLOTS];
  logic signed [10:0] r_y  [N_SLOTS];
  logic signed [7:0]  r_vx [N_SLOTS];
  logic signed [7:0]  r_vy [N_SLOTS];
  logic [N_SLOTS-1:0] r_active;

  logic           w_tick;
  logic           w_full;
  logic [IDW-1:0] w_free_idx;
  logic [9:0]     w_spawn_x;

  assign w_tick    = bus.frame_clk & ~r_frame_q;
  assign w_full    = &r_active;
  assign w_spawn_x = (bus.spawn_x > X_MAX) ? X_MAX : bus.spawn_x;

  always_comb begin
    w_free_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!r_active[i]) w_free_idx = IDW'(i);
    end
  end

  // Kinematics for the slot under the sweep pointer
  logic [9:0]         w_x_cur;
  logic signed [10:0] w_y_cur;
  logic signed [7:0]  w_vx_cur;
  logic signed [7:0]  w_vy_cur;
  logic signed [8:0]  w_vy_sum;
  logic signed [7:0]  w_vy_new;
  logic signed [10:0] w_y_new;
  logic signed [11:0] w_x_sum;
  logic signed [7:0]  w_vx_neg;
  logic [9:0]         w_x_new;
  logic signed [7:0]  w_vx_new;
  logic               w_upd_en;
  logic               w_retire;

  assign w_x_cur  = r_x[r_idx];
  assign w_y_cur  = r_y[r_idx];
  assign w_vx_cur = r_vx[r_idx];
  assign w_vy_cur = r_vy[r_idx];

  assign w_vy_sum = {w_vy_cur[7], w_vy_cur}
                  + {GRAVITY[7], GRAVITY};

  always_comb begin
    w_vy_new = w_vy_sum[7:0];
    if (w_vy_sum > 9'sd127) begin
      w_vy_new = 8'sd127;
    end else if (w_vy_sum < -9'sd128) begin
      w_vy_new = 8'sh80;
    end
  end

  assign w_y_new = w_y_cur + {{3{w_vy_new[7]}}, w_vy_new};

  assign w_x_sum = $signed({2'b00, w_x_cur})
                 + $signed({{4{w_vx_cur[7]}}, w_vx_cur});

  // -128 has no positive twin; bounce it to +127
  assign w_vx_neg = (w_vx_cur == 8'sh80) ? 8'sd127 : -w_vx_cur;

  always_comb begin
    w_x_new  = w_x_sum[9:0];
    w_vx_new = w_vx_cur;
    if (w_x_sum < 12'sd0) begin
      w_x_new  = '0;
      w_vx_new = w_vx_neg;
    end else if (w_x_sum > $signed({2'b00, X_MAX})) begin
      w_x_new  = X_MAX;
      w_vx_new = w_vx_neg;
    end
  end

  assign w_upd_en = (r_state == S_UPDATE) & r_active[r_idx];
  assign w_retire = (w_vy_new > 8'sd0) & (w_y_new > Y_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_UPDATE;
          w_idx_nxt   = '0;
        end else if (bus.spawn_req && !w_full) begin
          w_state_nxt = S_SPAWN;
        end
      end
      S_SPAWN: w_state_nxt = S_IDLE;
      S_UPDATE: begin
        if (r_idx == LAST) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    r_frame_q <= bus.frame_clk;
    if (Reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_active <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_x[i]  <= '0;
        r_y[i]  <= '0;
        r_vx[i] <= '0;
        r_vy[i] <= '0;
      end
    end else if (r_state == S_SPAWN) begin
      r_active[w_free_idx] <= 1'b1;
      r_x[w_free_idx]      <= w_spawn_x;
      r_y[w_free_idx]      <= Y_SPAWN;
      r_vx[w_free_idx]     <= bus.spawn_vx;
      r_vy[w_free_idx]     <= bus.spawn_vy;
    end else if (w_upd_en) begin
      r_x[r_idx]  <= w_x_new;
      r_y[r_idx]  <= w_y_new;
      r_vx[r_idx] <= w_vx_new;
      r_vy[r_idx] <= w_vy_new;
      if (w_retire) r_active[r_idx] <= 1'b0;
    end
  end

  // Per-slot hit test; unsigned wrap makes left/top misses huge
  logic [N_SLOTS-1:0] w_hit;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_hit
    logic [9:0] w_dx;
    logic [9:0] w_dy;
    assign w_dx = bus.DrawX - r_x[g];
    assign w_dy = bus.DrawY - r_y[g][9:0];
    assign w_hit[g] = r_active[g] & ~r_y[g][10]
                    & (w_dx < FRUIT_SIZE)
                    & (w_dy < FRUIT_SIZE);
  end

  logic           w_win;
  logic [IDW-1:0] w_win_id;

  always_comb begin
    w_win    = 1'b0;
    w_win_id = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_win    = 1'b1;
        w_win_id = IDW'(i);
      end
    end
  end

  logic           r_on;
  logic [9:0]     r_fx;
  logic [9:0]     r_fy;
  logic [9:0]     r_size;
  logic [IDW-1:0] r_id;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_on   <= 1'b0;
      r_fx   <= '0;
      r_fy   <= '0;
      r_size <= '0;
      r_id   <= '0;
    end else begin
      r_on   <= w_win;
      r_fx   <= w_win ? r_x[w_win_id] : '0;
      r_fy   <= w_win ? r_y[w_win_id][9:0] : '0;
      r_size <= w_win ? FRUIT_SIZE : '0;
      r_id   <= w_win_id;
    end
  end

  assign bus.FruitX      = r_fx;
  assign bus.FruitY      = r_fy;
  assign bus.Fruit_size  = r_size;
  assign bus.fruit_on    = r_on;
  assign bus.fruit_id    = r_id;
  assign bus.active_mask = r_active;
  assign bus.spawn_ack   = (r_state == S_SPAWN) & ~Reset;
  assign bus.missed      = w_upd_en & w_retire & ~Reset;

endmodule

// File: tb/tb_fruit_slot_scheduler.sv
// Directed bench for fruit_slot_scheduler: spawn, gravity,
// wall bounce, retire, arbitration and tick/spawn priority.
module tb_fruit_slot_scheduler;
  localparam int N = 4;

  logic clk;
  logic rst;
  int n_vec;
  int n_err;

  fruit_slot_scheduler_if #(.N_SLOTS(N)) bus ();

  fruit_slot_scheduler #(.N_SLOTS(N)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic fc);
    rst = 1'b1;
    bus.frame_clk = fc;
    bus.spawn_req = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
  endtask

  task automatic do_spawn(input string tag,
                          input logic [9:0] x,
                          input logic [7:0] vx,
                          input logic [7:0] vy);
    int lat;
    bus.spawn_x   = x;
    bus.spawn_vx  = vx;
    bus.spawn_vy  = vy;
    bus.spawn_req = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (bus.spawn_ack) begin
        lat = i;
        break;
      end
    end
    bus.spawn_req = 1'b0;
    cyc();
    check(tag, lat, 1);
  endtask

  task automatic frame(output logic [N-1:0] mm,
                       output int acks);
    bus.frame_clk = 1'b0;
    cyc();
    bus.frame_clk = 1'b1;
    cyc();
    bus.frame_clk = 1'b0;
    mm = '0;
    acks = 0;
    for (int i = 0; i < N; i++) begin
      if (bus.missed) mm[i] = 1'b1;
      if (bus.spawn_ack) acks++;
      cyc();
    end
  endtask

  task automatic probe(input string tag,
                       input logic [9:0] dx,
                       input logic [9:0] dy,
                       input logic on,
                       input logic [9:0] fx,
                       input logic [9:0] fy,
                       input logic [1:0] id);
    bus.DrawX = dx;
    bus.DrawY = dy;
    cyc();
    check({tag, ".on"}, bus.fruit_on, on);
    check({tag, ".x"}, bus.FruitX, fx);
    check({tag, ".y"}, bus.FruitY, fy);
    check({tag, ".id"}, bus.fruit_id, id);
    check({tag, ".sz"}, bus.Fruit_size, on ? 32 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] mm;
    int acks;
    int lat;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.frame_clk = 1'b0;
    bus.DrawX = '0;
    bus.DrawY = '0;
    bus.spawn_req = 1'b0;
    bus.spawn_x = '0;
    bus.spawn_vx = '0;
    bus.spawn_vy = '0;

    // A: reset with vsync high, spawn, one and two frames
    do_reset(1'b1);
    check("A.rst.mask", bus.active_mask, 0);
    check("A.rst.on", bus.fruit_on, 0);
    check("A.rst.fx", bus.FruitX, 0);
    check("A.rst.fy", bus.FruitY, 0);
    check("A.rst.sz", bus.Fruit_size, 0);
    check("A.rst.id", bus.fruit_id, 0);
    check("A.rst.ack", bus.spawn_ack, 0);
    check("A.rst.miss", bus.missed, 0);
    do_spawn("A.ack", 10'd100, 8'd2, 8'hF6);
    check("A.mask", bus.active_mask, 4'b0001);
    probe("A.p0", 10'd100, 10'd479, 1, 10'd100, 10'd479, 0);
    probe("A.p1", 10'd99, 10'd479, 0, 0, 0, 0);
    probe("A.p2", 10'd131, 10'd510, 1, 10'd100, 10'd479, 0);
    probe("A.p3", 10'd100, 10'd511, 0, 0, 0, 0);
    frame(mm, acks);
    check("A.f1.miss", mm, 0);
    probe("A.f1", 10'd102, 10'd470, 1, 10'd102, 10'd470, 0);
    frame(mm, acks);
    probe("A.f2", 10'd104, 10'd462, 1, 10'd104, 10'd462, 0);

    // B: fill, blocked fifth spawn, retire slot 2, refill
    do_reset(1'b0);
    do_spawn("B.ack0", 10'd300, 8'd0, 8'hEC);
    do_spawn("B.ack1", 10'd350, 8'd0, 8'hEC);
    do_spawn("B.ack2", 10'd50, 8'd0, 8'd0);
    do_spawn("B.ack3", 10'd500, 8'd0, 8'hEC);
    check("B.mask", bus.active_mask, 4'b1111);
    bus.spawn_x = 10'd400;
    bus.spawn_vx = 8'd0;
    bus.spawn_vy = 8'hE2;
    bus.spawn_req = 1'b1;
    acks = 0;
    repeat (5) begin
      cyc();
      if (bus.spawn_ack) acks++;
    end
    check("B.full_noack", acks, 0);
    frame(mm, acks);
    check("B.f1.miss", mm, 0);
    check("B.f1.ack", acks, 0);
    cyc();
    check("B.idle_noack", bus.spawn_ack, 0);
    frame(mm, acks);
    check("B.f2.miss", mm, 4'b0100);
    check("B.f2.ack", acks, 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (bus.spawn_ack) begin
        lat = i;
        break;
      end
    end
    check("B.refill_ack", lat, 1);
    bus.spawn_req = 1'b0;
    cyc();
    check("B.mask2", bus.active_mask, 4'b1111);
    probe("B.p2", 10'd400, 10'd479, 1, 10'd400, 10'd479, 2);

    // C: wall bounces, spawn clamp, -128 bounce
    do_reset(1'b0);
    do_spawn("C.ack0", 10'd606, 8'd5, 8'hEC);
    do_spawn("C.ack1", 10'd1, 8'hFD, 8'hEC);
    frame(mm, acks);
    check("C.f1.miss", mm, 0);
    probe("C.r1", 10'd607, 10'd460, 1, 10'd607, 10'd460, 0);
    probe("C.l1", 10'd0, 10'd460, 1, 10'd0, 10'd460, 1);
    frame(mm, acks);
    probe("C.r2", 10'd602, 10'd442, 1, 10'd602, 10'd442, 0);
    probe("C.l2", 10'd3, 10'd442, 1, 10'd3, 10'd442, 1);
    do_spawn("C.ack2", 10'd900, 8'd0, 8'hEC);
    do_spawn("C.ack3", 10'd50, 8'h80, 8'hEC);
    probe("C.clamp", 10'd607, 10'd479, 1, 10'd607, 10'd479, 2);
    frame(mm, acks);
    probe("C.m1", 10'd0, 10'd460, 1, 10'd0, 10'd460, 3);
    frame(mm, acks);
    probe("C.m2", 10'd127, 10'd442, 1, 10'd127, 10'd442, 3);

    // D: overlap of slots 1 and 3 after 0 and 2 retire
    do_reset(1'b0);
    do_spawn("D.ack0", 10'd600, 8'd0, 8'd0);
    do_spawn("D.ack1", 10'd200, 8'd0, 8'hEC);
    do_spawn("D.ack2", 10'd400, 8'd0, 8'd0);
    do_spawn("D.ack3", 10'd200, 8'd0, 8'hEC);
    frame(mm, acks);
    check("D.f1.miss", mm, 0);
    frame(mm, acks);
    check("D.f2.miss", mm, 4'b0101);
    check("D.mask", bus.active_mask, 4'b1010);
    probe("D.ov", 10'd210, 10'd452, 1, 10'd200, 10'd442, 1);
    probe("D.off", 10'd250, 10'd250, 0, 0, 0, 0);

    // E: tick and spawn in the same cycle
    do_reset(1'b0);
    bus.spawn_x = 10'd10;
    bus.spawn_vx = 8'd0;
    bus.spawn_vy = 8'hEC;
    bus.frame_clk = 1'b1;
    bus.spawn_req = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      bus.frame_clk = 1'b0;
      if (bus.spawn_ack) begin
        lat = i;
        break;
      end
    end
    check("E.lat", lat, N + 2);
    bus.spawn_req = 1'b0;
    cyc();
    check("E.mask", bus.active_mask, 4'b0001);

    // F: reset landing on a retiring update cycle
    do_reset(1'b0);
    do_spawn("F.ack", 10'd100, 8'd0, 8'd0);
    frame(mm, acks);
    bus.frame_clk = 1'b0;
    cyc();
    bus.frame_clk = 1'b1;
    cyc();
    rst = 1'b1;
    #1;
    check("F.miss_rst", bus.missed, 0);
    cyc();
    rst = 1'b0;
    bus.frame_clk = 1'b0;
    check("F.mask", bus.active_mask, 0);
    check("F.ack", bus.spawn_ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
